// File: rtl/apb_slave_mem_pkg.sv
// Shared types and helpers for the memory-backed APB completer.
package apb_slave_mem_pkg;

  // Transfer sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_e;

  // Width of the wait-state down-counter (supports 0..15 wait states)
  localparam int WAIT_CNT_W = 4;

  // Number of byte-offset bits below the word index
  function automatic int calc_addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_slave_mem_ram.sv
// Single-port synchronous RAM with per-byte write enables.
// The read port is registered and reads back zero in any cycle without a
// read request, so the top can drive it straight onto the bus data output.
module apb_slave_mem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int AW         = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic                    re_i,
  input  logic [AW-1:0]           addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-lane write; storage itself is never reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Registered read data, zero whenever no read is requested
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
    else           rdata_q <= '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by an internal RAM with configurable wait states.
// Out-of-range or unaligned accesses complete with pslverr and touch no RAM.
// All bus outputs are registered.
// Optional build macro APB_SLAVE_MEM_PSTRB_EN adds APB4 byte strobes (pstrb).
module apb_slave_mem
  import apb_slave_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_SLAVE_MEM_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);

  localparam int ADDR_LSB = calc_addr_lsb(DATA_WIDTH);
  localparam int NB       = DATA_WIDTH / 8;
  localparam int AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << ADDR_LSB) - 1);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  pready_q, pslverr_q;
  logic                  setup;

  // Transfer context captured in the setup phase
  logic [AW-1:0]         addr_q;
  logic                  pwrite_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;

  logic [ADDR_WIDTH-1:0] idx_full;
  logic [AW-1:0]         idx_in;
  logic                  err_in;
  logic                  enter_ready;
  logic                  cur_wr, cur_err;
  logic                  ram_we, ram_re;
  logic [AW-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Address decode: word index plus alignment and range checks.
  // The extra top bit keeps the range compare exact when MEM_DEPTH fills the space.
  assign idx_full = paddr >> ADDR_LSB;
  assign idx_in   = idx_full[AW-1:0];
  assign err_in   = (|(paddr & LSB_MASK)) ||
                    ({1'b0, idx_full} >= (ADDR_WIDTH+1)'(MEM_DEPTH));

  // Next-state logic for setup / wait / completion sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    setup   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // penable without a preceding setup phase is ignored
        if (psel && !penable) begin
          setup = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = READY;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (!psel)            state_d = IDLE;
        else if (cnt_q == '0) state_d = READY;
        else                  cnt_d   = cnt_q - WAIT_CNT_W'(1);
      end
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // On a zero-wait transfer READY is entered straight from the setup edge,
  // so the live bus values stand in for the not-yet-latched ones.
  assign enter_ready = (state_d == READY);
  assign cur_wr      = setup ? pwrite : pwrite_q;
  assign cur_err     = setup ? err_in : err_q;
  assign ram_addr    = (state_q == IDLE) ? idx_in : addr_q;
  assign ram_re      = enter_ready && !cur_wr && !cur_err;
  assign ram_we      = (state_q == READY) && psel && penable && pwrite_q && !err_q;

  // Control state and registered response flags
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= enter_ready;
      pslverr_q <= enter_ready && cur_err;
    end
  end

  // Capture the transfer context in the setup phase
  always_ff @(posedge pclk) begin
    if (setup) begin
      addr_q   <= idx_in;
      pwrite_q <= pwrite;
      err_q    <= err_in;
      wdata_q  <= pwdata;
`ifdef APB_SLAVE_MEM_PSTRB_EN
      strb_q   <= pstrb;
`else
      strb_q   <= {NB{1'b1}};
`endif
    end
  end

  apb_slave_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk_i   (pclk),
    .rst_ni  (presetn),
    .we_i    (ram_we),
    .be_i    (strb_q),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = ram_rdata;

endmodule
